// File: rtl/pool_window_feeder_pkg.sv
// Shared types and defaults for the 4x4 pooling window feeder.
// The optional window counter is enabled with POOL_WINDOW_FEEDER_STATS_EN.
package pool_window_feeder_pkg;

  typedef enum logic {
    S_FILL = 1'b0,
    S_LAST = 1'b1
  } fsm_state_t;

  localparam int DEF_DW    = 8;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int LB_ROWS   = 3;
  localparam int WIN_PIX   = 4;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Three buffered band rows, each IMG_W/4 words of four packed pixels.
// Every row has its own write port and asynchronous read port.
module pool_line_buffer
  import pool_window_feeder_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int IMG_W = DEF_IMG_W,
  parameter int DEPTH = IMG_W / WIN_PIX,
  parameter int AW    = clog2_min1(DEPTH),
  parameter int WW    = WIN_PIX * DW
) (
  input  logic                           clk,
  input  logic [LB_ROWS-1:0]             wr_en,
  input  logic [LB_ROWS-1:0][AW-1:0]     wr_addr,
  input  logic [LB_ROWS-1:0][WW-1:0]     wr_data,
  input  logic [LB_ROWS-1:0][AW-1:0]     rd_addr,
  output logic [LB_ROWS-1:0][WW-1:0]     rd_data
);

  for (genvar r = 0; r < LB_ROWS; r++) begin : g_row
    logic [WW-1:0] mem [DEPTH];

    // Contents are never reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
      if (wr_en[r]) mem[wr_addr[r]] <= wr_data[r];
    end

    assign rd_data[r] = mem[rd_addr[r]];
  end

endmodule

// File: rtl/pool_window_feeder.sv
// Raster pixel stream to non-overlapping 4x4 windows for a 16:1 max pooler.
// Define POOL_WINDOW_FEEDER_STATS_EN to add the saturating win_count output.
module pool_window_feeder
  import pool_window_feeder_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   pix_in,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic [4*DW-1:0] win_a,
  output logic [4*DW-1:0] win_b,
  output logic [4*DW-1:0] win_c,
  output logic [4*DW-1:0] win_d,
  output logic            win_valid,
  input  logic            win_ready,
  output logic            win_last
`ifdef POOL_WINDOW_FEEDER_STATS_EN
  ,
  output logic [15:0]     win_count
`endif
);

  localparam int WW    = WIN_PIX * DW;
  localparam int CW    = clog2_min1(IMG_W);
  localparam int BW    = clog2_min1(IMG_H / 4);
  localparam int DEPTH = IMG_W / WIN_PIX;
  localparam int AW    = clog2_min1(DEPTH);

  fsm_state_t state, state_nxt;

  logic [CW-1:0]   col;
  logic [1:0]      band_row;
  logic [BW-1:0]   band;
  logic [3*DW-1:0] sr;

  logic            pix_acc, col_end, grp_end, band_end, load;
  logic [AW-1:0]   grp;
  logic [WW-1:0]   packed_word;

  logic [LB_ROWS-1:0]           lb_we;
  logic [LB_ROWS-1:0][AW-1:0]   lb_waddr, lb_raddr;
  logic [LB_ROWS-1:0][WW-1:0]   lb_wdata, lb_rdata;

  assign pix_ready   = !win_valid || win_ready;
  assign pix_acc     = pix_valid && pix_ready;
  assign col_end     = (col == CW'(IMG_W - 1));
  assign grp_end     = &col[1:0];
  assign band_end    = (band == BW'(IMG_H / 4 - 1));
  assign grp         = AW'(col >> 2);
  // Column 4k+0 lands in the top bits: oldest pixel shifted furthest left.
  assign packed_word = {sr, pix_in};
  // A load only happens on a pixel acceptance, which implies the window slot is free.
  assign load        = pix_acc && grp_end && (state == S_LAST);

  for (genvar r = 0; r < LB_ROWS; r++) begin : g_lb_port
    assign lb_we[r]    = pix_acc && grp_end && (state == S_FILL) && (band_row == 2'(r));
    assign lb_waddr[r] = grp;
    assign lb_wdata[r] = packed_word;
    assign lb_raddr[r] = grp;
  end

  pool_line_buffer #(
    .DW    (DW),
    .IMG_W (IMG_W),
    .DEPTH (DEPTH),
    .AW    (AW),
    .WW    (WW)
  ) u_lb (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_addr (lb_waddr),
    .wr_data (lb_wdata),
    .rd_addr (lb_raddr),
    .rd_data (lb_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: if (pix_acc && col_end && band_row == 2'd2) state_nxt = S_LAST;
      S_LAST: if (pix_acc && col_end)                     state_nxt = S_FILL;
      default:                                            state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col      <= '0;
      band_row <= '0;
      band     <= '0;
      sr       <= '0;
    end else if (pix_acc) begin
      sr <= {sr[2*DW-1:0], pix_in};
      if (col_end) begin
        col      <= '0;
        band_row <= band_row + 2'd1;
        if (band_row == 2'd3) band <= band_end ? '0 : band + BW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_a     <= '0;
      win_b     <= '0;
      win_c     <= '0;
      win_d     <= '0;
    end else if (load) begin
      win_valid <= 1'b1;
      win_last  <= band_end && col_end;
      win_a     <= lb_rdata[0];
      win_b     <= lb_rdata[1];
      win_c     <= lb_rdata[2];
      win_d     <= packed_word;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

`ifdef POOL_WINDOW_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                           win_count <= '0;
    else if (win_valid && win_ready && win_count != 16'hFFFF) win_count <= win_count + 16'd1;
  end
`endif

endmodule
